axi_lite_master: RTL

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// AXI4-Lite master bridge: accepts one read or write command at a time, issues it on
// AR or AW+W, tracks outstanding read IDs and write count, and returns R/B beats as
// single-entry responses.
module axi_lite_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MAX_WR     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic                          cmd_write,
  input  logic [ADDR_WIDTH-1:0]         cmd_addr,
  input  logic [DATA_WIDTH-1:0]         cmd_wdata,
  output logic [ADDR_WIDTH-1:0]         araddr,
  output logic [ID_WIDTH-1:0]           arid,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic [ID_WIDTH-1:0]           rid,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic                          bvalid,
  output logic                          bready,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic                          rsp_write,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic [ID_WIDTH:0]             rd_outstanding,
  output logic [$clog2(MAX_WR+1)-1:0]   wr_outstanding,
  output logic                          err
);

  localparam int unsigned N_IDS = 2**ID_WIDTH;
  localparam int unsigned WCW   = $clog2(MAX_WR+1);
  localparam int unsigned RCW   = ID_WIDTH + 1;

  logic [N_IDS-1:0]      busy_q,      busy_d;
  logic [WCW-1:0]        wr_cnt_q,    wr_cnt_d;
  logic                  arvalid_q,   arvalid_d;
  logic [ADDR_WIDTH-1:0] araddr_q,    araddr_d;
  logic [ID_WIDTH-1:0]   arid_q,      arid_d;
  logic                  awvalid_q,   awvalid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,    awaddr_d;
  logic                  wvalid_q,    wvalid_d;
  logic [DATA_WIDTH-1:0] wdata_q,     wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [ID_WIDTH-1:0]   rsp_id_q,    rsp_id_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  err_q,       err_d;

  logic [ID_WIDTH-1:0]   free_id;
  logic                  any_free;
  logic                  rd_acc, wr_acc;
  logic                  r_hs, b_hs, r_ok, b_ok;

  // Lowest-numbered free read ID (priority search over the busy map)
  always_comb begin
    free_id  = '0;
    any_free = 1'b0;
    for (int unsigned i = 0; i < N_IDS; i++) begin
      if (!busy_q[i] && !any_free) begin
        free_id  = ID_WIDTH'(i);
        any_free = 1'b1;
      end
    end
  end

  // Number of busy read IDs
  always_comb begin
    rd_outstanding = '0;
    for (int unsigned i = 0; i < N_IDS; i++) begin
      rd_outstanding = rd_outstanding + RCW'(busy_q[i]);
    end
  end

  // Handshake qualification; R has priority over B when the response slot is free
  always_comb begin
    cmd_ready = ~arvalid_q & ~awvalid_q & ~wvalid_q & any_free & (wr_cnt_q < WCW'(MAX_WR));
    rready    = ~rsp_valid_q | rsp_ready;
    bready    = (~rsp_valid_q | rsp_ready) & ~rvalid;
    rd_acc    = cmd_valid & cmd_ready & ~cmd_write;
    wr_acc    = cmd_valid & cmd_ready &  cmd_write;
    r_hs      = rvalid & rready;
    b_hs      = bvalid & bready;
    r_ok      = r_hs & busy_q[rid];
    b_ok      = b_hs & (wr_cnt_q != '0);
  end

  // Next-state: channel issue, ID/write bookkeeping, response slot and error flag
  always_comb begin
    busy_d      = busy_q;
    wr_cnt_d    = wr_cnt_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arid_d      = arid_q;
    awvalid_d   = awvalid_q;
    awaddr_d    = awaddr_q;
    wvalid_d    = wvalid_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_id_d    = rsp_id_q;
    rsp_rdata_d = rsp_rdata_q;
    err_d       = err_q | (r_hs & ~r_ok) | (b_hs & ~b_ok);

    if (arvalid_q && arready) arvalid_d = 1'b0;
    if (awvalid_q && awready) awvalid_d = 1'b0;
    if (wvalid_q  && wready)  wvalid_d  = 1'b0;

    // free_id is never busy, so a same-cycle R release cannot collide with it
    if (rd_acc) begin
      busy_d[free_id] = 1'b1;
      arvalid_d       = 1'b1;
      araddr_d        = cmd_addr;
      arid_d          = free_id;
    end
    if (wr_acc) begin
      awvalid_d = 1'b1;
      awaddr_d  = cmd_addr;
      wvalid_d  = 1'b1;
      wdata_d   = cmd_wdata;
    end

    if (wr_acc && !b_ok)      wr_cnt_d = wr_cnt_q + WCW'(1);
    else if (!wr_acc && b_ok) wr_cnt_d = wr_cnt_q - WCW'(1);

    if (rsp_valid_q && rsp_ready) rsp_valid_d = 1'b0;
    if (r_ok) begin
      busy_d[rid] = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_write_d = 1'b0;
      rsp_id_d    = rid;
      rsp_rdata_d = rdata;
    end else if (b_ok) begin
      rsp_valid_d = 1'b1;
      rsp_write_d = 1'b1;
      rsp_id_d    = '0;
      rsp_rdata_d = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q      <= '0;
      wr_cnt_q    <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arid_q      <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_rdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      busy_q      <= busy_d;
      wr_cnt_q    <= wr_cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arid_q      <= arid_d;
      awvalid_q   <= awvalid_d;
      awaddr_q    <= awaddr_d;
      wvalid_q    <= wvalid_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_id_q    <= rsp_id_d;
      rsp_rdata_q <= rsp_rdata_d;
      err_q       <= err_d;
    end
  end

  // Registered outputs
  always_comb begin
    arvalid        = arvalid_q;
    araddr         = araddr_q;
    arid           = arid_q;
    awvalid        = awvalid_q;
    awaddr         = awaddr_q;
    wvalid         = wvalid_q;
    wdata          = wdata_q;
    rsp_valid      = rsp_valid_q;
    rsp_write      = rsp_write_q;
    rsp_id         = rsp_id_q;
    rsp_rdata      = rsp_rdata_q;
    wr_outstanding = wr_cnt_q;
    err            = err_q;
  end

endmodule
